param_alu_seq: RTL

Parametrised, handshaked successor to the 4-bit registered ALU, keeping the same 16-entry opcode map. Operands are WIDTH-bit signed and the result is 2*WIDTH-bit signed. Multiply runs as an iterative shift-add over WIDTH cycles. All other ops complete in one cycle. Outputs are registered and held until the consumer accepts them; status flags are added. It sits between an operand source and a result sink on valid/ready streams.

---
 rtl/param_alu_pkg.sv | 27 ++
 rtl/alu_seq_mul.sv | 63 ++++++
 rtl/param_alu_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/param_alu_pkg.sv
// Shared opcode map and FSM state encoding for param_alu_seq.
package param_alu_pkg;

    localparam logic [3:0] OP_INCA  = 4'b0000;
    localparam logic [3:0] OP_INCB  = 4'b0001;
    localparam logic [3:0] OP_PASSA = 4'b0010;
    localparam logic [3:0] OP_PASSB = 4'b0011;
    localparam logic [3:0] OP_DECA  = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_ADD   = 4'b0110;
    localparam logic [3:0] OP_SUB   = 4'b0111;
    localparam logic [3:0] OP_NOTA  = 4'b1000;
    localparam logic [3:0] OP_NOTB  = 4'b1001;
    localparam logic [3:0] OP_AND   = 4'b1010;
    localparam logic [3:0] OP_OR    = 4'b1011;
    localparam logic [3:0] OP_XOR   = 4'b1100;
    localparam logic [3:0] OP_XNOR  = 4'b1101;
    localparam logic [3:0] OP_NAND  = 4'b1110;
    localparam logic [3:0] OP_NOR   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative signed multiplier: operands captured on start, one shift-add
// partial product per cycle, done pulses on the last iteration with the product.
module alu_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]  mag_a, mag_b;
    logic            neg;
    logic [RW-1:0]   acc, partial, sum;
    logic [CW-1:0]   cnt;
    logic            running;

    // WIDTH+1 bits so the most negative operand has a representable magnitude
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] ext;
        ext = {x[WIDTH-1], x};
        return x[WIDTH-1] ? (~ext + {{WIDTH{1'b0}}, 1'b1}) : ext;
    endfunction

    assign partial = mag_b[cnt] ? (RW'(mag_a) << cnt) : '0;
    assign sum     = acc + partial;
    assign done    = running && (cnt == CW'(WIDTH - 1));
    assign product = neg ? (~sum + {{(RW-1){1'b0}}, 1'b1}) : sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            if (done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mag_a <= magnitude(a);
            mag_b <= magnitude(b);
            neg   <= a[WIDTH-1] ^ b[WIDTH-1];
            acc   <= '0;
        end else if (running) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/param_alu_seq.sv
// Handshaked WIDTH-bit signed ALU with iterative multiply and status flags.
// Define ALU_SATURATE_EN to clamp out-of-range arithmetic results to WIDTH-bit signed.
module param_alu_seq
    import param_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_v,
    output logic                 busy
);
    localparam int RW = 2 * WIDTH;
    localparam logic signed [RW-1:0] ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic signed [RW-1:0] MAXV = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t state, state_nxt;
    logic   mul_start, mul_done, load;
    logic   arith, ovf;
    logic [WIDTH-1:0]      lres;
    logic signed [RW-1:0]  a_ext, b_ext, exact, res, mul_product;

    function automatic logic fits(input logic signed [RW-1:0] x);
        return (x >= MINV) && (x <= MAXV);
    endfunction

`ifdef ALU_SATURATE_EN
    function automatic logic signed [RW-1:0] saturate(input logic signed [RW-1:0] x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction
`endif

    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (sel == OP_MUL) begin
                        state_nxt = MUL;
                        mul_start = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        load      = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_nxt = DONE;
                    load      = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL);

    // Operands are only live in IDLE; in MUL the result comes from the multiplier
    always_comb begin
        exact = '0;
        lres  = '0;
        arith = 1'b0;
        if (state == MUL) begin
            exact = mul_product;
            arith = 1'b1;
        end else begin
            case (sel)
                OP_INCA:  begin exact = a_ext + ONE;   arith = 1'b1; end
                OP_INCB:  begin exact = b_ext + ONE;   arith = 1'b1; end
                OP_PASSA: exact = a_ext;
                OP_PASSB: exact = b_ext;
                OP_DECA:  begin exact = a_ext - ONE;   arith = 1'b1; end
                OP_MUL:   arith = 1'b1;
                OP_ADD:   begin exact = a_ext + b_ext; arith = 1'b1; end
                OP_SUB:   begin exact = a_ext - b_ext; arith = 1'b1; end
                OP_NOTA:  lres = ~a;
                OP_NOTB:  lres = ~b;
                OP_AND:   lres = a & b;
                OP_OR:    lres = a | b;
                OP_XOR:   lres = a ^ b;
                OP_XNOR:  lres = ~(a ^ b);
                OP_NAND:  lres = ~(a & b);
                default:  lres = ~(a | b);
            endcase
            if (sel[3]) exact = {{WIDTH{lres[WIDTH-1]}}, lres};
        end
        ovf = arith && !fits(exact);
`ifdef ALU_SATURATE_EN
        res = arith ? saturate(exact) : exact;
`else
        res = exact;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y      <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else if (load) begin
            y      <= res;
            flag_z <= (res == '0);
            flag_n <= res[RW-1];
            flag_v <= ovf;
        end
    end

endmodule
